// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: round-robin share of one main-memory read/write port pair between fetch (read) and data (read+write) requesters, registered outputs, per-requester grant counters
module main_mem_arbiter #(
  parameter int COUNT_WIDTH = 32,
  parameter bit FETCH_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            fetch_out_addr,
  input  logic                   fetch_out_valid,
  output logic [31:0]            fetch_out_data,
  output logic                   fetch_out_ready,
  input  logic [31:0]            data_out_addr,
  input  logic                   data_out_valid,
  output logic [31:0]            data_out_data,
  output logic                   data_out_ready,
  input  logic [31:0]            data_in_addr,
  input  logic [31:0]            data_in_data,
  input  logic                   data_in_valid,
  output logic                   data_in_ready,
  output logic [31:0]            main_mem_out_addr,
  output logic                   main_mem_out_valid,
  input  logic [31:0]            main_mem_out_data,
  input  logic                   main_mem_out_ready,
  output logic [31:0]            main_mem_in_addr,
  output logic [31:0]            main_mem_in_data,
  output logic                   main_mem_in_valid,
  input  logic                   main_mem_in_ready,
  output logic [COUNT_WIDTH-1:0] grant_fetch_count,
  output logic [COUNT_WIDTH-1:0] grant_data_count
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [1:0] OWN_F = 2'd0, OWN_R = 2'd1, OWN_W = 2'd2;
  state_t state_q, state_d;
  logic [1:0] own_q, own_d;
  logic prio_f_q, prio_f_d;
  logic [31:0] mo_addr_q, mo_addr_d, mi_addr_q, mi_addr_d, mi_data_q, mi_data_d;
  logic [31:0] f_data_q, f_data_d, d_data_q, d_data_d;
  logic mo_valid_q, mo_valid_d, mi_valid_q, mi_valid_d;
  logic f_rdy_q, f_rdy_d, dr_rdy_q, dr_rdy_d, dw_rdy_q, dw_rdy_d;
  logic [COUNT_WIDTH-1:0] f_cnt_q, f_cnt_d, d_cnt_q, d_cnt_d;
  logic f_pend, d_pend, grant, grant_f, done;
  assign f_pend = fetch_out_valid;
  assign d_pend = data_out_valid | data_in_valid;
  assign grant = (state_q == IDLE) & (f_pend | d_pend);
  assign grant_f = f_pend & (~d_pend | prio_f_q);
  assign done = (state_q == BUSY) & ((mo_valid_q & main_mem_out_ready) | (mi_valid_q & main_mem_in_ready));
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      own_q      <= OWN_F;
      prio_f_q   <= FETCH_FIRST;
      mo_addr_q  <= '0;
      mi_addr_q  <= '0;
      mi_data_q  <= '0;
      f_data_q   <= '0;
      d_data_q   <= '0;
      mo_valid_q <= 1'b0;
      mi_valid_q <= 1'b0;
      f_rdy_q    <= 1'b0;
      dr_rdy_q   <= 1'b0;
      dw_rdy_q   <= 1'b0;
      f_cnt_q    <= '0;
      d_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      prio_f_q   <= prio_f_d;
      mo_addr_q  <= mo_addr_d;
      mi_addr_q  <= mi_addr_d;
      mi_data_q  <= mi_data_d;
      f_data_q   <= f_data_d;
      d_data_q   <= d_data_d;
      mo_valid_q <= mo_valid_d;
      mi_valid_q <= mi_valid_d;
      f_rdy_q    <= f_rdy_d;
      dr_rdy_q   <= dr_rdy_d;
      dw_rdy_q   <= dw_rdy_d;
      f_cnt_q    <= f_cnt_d;
      d_cnt_q    <= d_cnt_d;
    end
  end
  always_comb
    state_d = state_q == IDLE ? (grant ? BUSY : IDLE) : state_q == BUSY ? (done ? RESP : BUSY) : IDLE;
  always_comb begin
    own_d      = own_q;
    prio_f_d   = prio_f_q;
    mo_addr_d  = mo_addr_q;
    mi_addr_d  = mi_addr_q;
    mi_data_d  = mi_data_q;
    mo_valid_d = mo_valid_q;
    mi_valid_d = mi_valid_q;
    f_data_d   = f_data_q;
    d_data_d   = d_data_q;
    f_cnt_d    = f_cnt_q;
    d_cnt_d    = d_cnt_q;
    f_rdy_d    = 1'b0;
    dr_rdy_d   = 1'b0;
    dw_rdy_d   = 1'b0;
    if (grant) begin
      own_d    = grant_f ? OWN_F : data_out_valid ? OWN_R : OWN_W;
      prio_f_d = ~grant_f;
      if (grant_f || data_out_valid) begin
        mo_addr_d  = grant_f ? fetch_out_addr : data_out_addr;
        mo_valid_d = 1'b1;
      end else begin
        mi_addr_d  = data_in_addr;
        mi_data_d  = data_in_data;
        mi_valid_d = 1'b1;
      end
    end
    if (done) begin
      mo_valid_d = 1'b0;
      mi_valid_d = 1'b0;
      f_rdy_d    = own_q == OWN_F;
      dr_rdy_d   = own_q == OWN_R;
      dw_rdy_d   = own_q == OWN_W;
      f_data_d   = own_q == OWN_F ? main_mem_out_data : f_data_q;
      d_data_d   = own_q == OWN_R ? main_mem_out_data : d_data_q;
      f_cnt_d    = own_q == OWN_F ? f_cnt_q + COUNT_WIDTH'(1) : f_cnt_q;
      d_cnt_d    = own_q != OWN_F ? d_cnt_q + COUNT_WIDTH'(1) : d_cnt_q;
    end
  end
  assign fetch_out_data     = f_data_q;
  assign fetch_out_ready    = f_rdy_q;
  assign data_out_data      = d_data_q;
  assign data_out_ready     = dr_rdy_q;
  assign data_in_ready      = dw_rdy_q;
  assign main_mem_out_addr  = mo_addr_q;
  assign main_mem_out_valid = mo_valid_q;
  assign main_mem_in_addr   = mi_addr_q;
  assign main_mem_in_data   = mi_data_q;
  assign main_mem_in_valid  = mi_valid_q;
  assign grant_fetch_count  = f_cnt_q;
  assign grant_data_count   = d_cnt_q;
endmodule
